// File: rtl/afe_seq_pkg.sv
// Shared types and constants for the AFE readout sequencer.
package afe_seq_pkg;

   localparam int TMR_W = 16;
   localparam int CH_W  = 6;

   localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_IRST   = 4'd1,
      ST_SHR    = 4'd2,
      ST_INTG   = 4'd3,
      ST_SHS    = 4'd4,
      ST_CLK_HI = 4'd5,
      ST_CLK_LO = 4'd6,
      ST_SETTLE = 4'd7,
      ST_CONV   = 4'd8,
      ST_WAIT   = 4'd9,
      ST_DONE   = 4'd10
   } seq_state_t;

endpackage

// File: rtl/afe_readout_seq_if.sv
// Bundle of the AFE strobes, ADS handshake and pixel output of the sequencer.
interface afe_readout_seq_if;

   logic        ADS_INIT_OK;
   logic        FRAME_START;
   logic        AFE_IRST;
   logic        AFE_SHR;
   logic        AFE_INTG;
   logic        AFE_SHS;
   logic        AFE_CLK;
   logic        CONV_REQ;
   logic        ADS_AVLAID;
   logic [15:0] ADS_ADATA;
   logic        PIX_VALID;
   logic [15:0] PIX_DATA;
   logic [5:0]  PIX_CH;
   logic        SEQ_BUSY;
   logic        FRAME_DONE;
   logic        ERR_TIMEOUT;
   logic        ERR_ABORT;

   // sequencer side
   modport master (
      input  ADS_INIT_OK, FRAME_START, ADS_AVLAID, ADS_ADATA,
      output AFE_IRST, AFE_SHR, AFE_INTG, AFE_SHS, AFE_CLK, CONV_REQ,
             PIX_VALID, PIX_DATA, PIX_CH, SEQ_BUSY, FRAME_DONE,
             ERR_TIMEOUT, ERR_ABORT
   );

   // AFE / ADS / pixel consumer side
   modport slave (
      output ADS_INIT_OK, FRAME_START, ADS_AVLAID, ADS_ADATA,
      input  AFE_IRST, AFE_SHR, AFE_INTG, AFE_SHS, AFE_CLK, CONV_REQ,
             PIX_VALID, PIX_DATA, PIX_CH, SEQ_BUSY, FRAME_DONE,
             ERR_TIMEOUT, ERR_ABORT
   );

endinterface

// File: rtl/afe_readout_seq_timer.sv
// Loadable down-counter; holds at zero and flags it.
module seq_timer
   import afe_seq_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] cnt;

   // load on state entry, otherwise count down to zero and stop
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/afe_readout_seq.sv
// AFE frame sequencer: integrate/sample strobes, per-channel AFE clocking,
// ADS conversion handshake and tagged pixel output.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   IDLE      | waiting for FRAME_START with ADS_INIT_OK
//   IRST      | AFE integrator reset (IRST_CYC)
//   SHR       | sample reset level (SH_CYC)
//   INTG      | integrate (INTG_CYC)
//   SHS       | sample signal level (SH_CYC)
//   CLK_HI    | AFE_CLK high (CLK_HALF)
//   CLK_LO    | AFE_CLK low (CLK_HALF)
//   SETTLE    | analog output settle (SETTLE_CYC)
//   CONV      | one-cycle ADS conversion request
//   WAIT      | wait for ADS data, up to CONV_TIMEOUT cycles
//   DONE      | one-cycle frame end
module afe_readout_seq
   import afe_seq_pkg::*;
#(
   parameter int CH_NUM       = 64,
   parameter int IRST_CYC     = 100,
   parameter int SH_CYC       = 20,
   parameter int INTG_CYC     = 10000,
   parameter int CLK_HALF     = 10,
   parameter int SETTLE_CYC   = 20,
   parameter int CONV_TIMEOUT = 255
)
(
   input  logic               CLK_100M,
   input  logic               CLK_RST,
   afe_readout_seq_if.master  bus
);

   seq_state_t        state, nxt;
   logic [CH_W-1:0]   ch;
   logic              ch_inc;
   logic              pix_take;
   logic              pix_fill;
   logic              abort;
   logic              t_load;
   logic [TMR_W-1:0]  t_val;
   logic              t_zero;
   logic              last_ch;

   // timer reload value for a state is its duration minus one
   function automatic logic [TMR_W-1:0] dur_of(input seq_state_t s);
      case (s)
         ST_IRST:             dur_of = TMR_W'(IRST_CYC - 1);
         ST_SHR, ST_SHS:      dur_of = TMR_W'(SH_CYC - 1);
         ST_INTG:             dur_of = TMR_W'(INTG_CYC - 1);
         ST_CLK_HI, ST_CLK_LO: dur_of = TMR_W'(CLK_HALF - 1);
         ST_SETTLE:           dur_of = TMR_W'(SETTLE_CYC - 1);
         ST_WAIT:             dur_of = TMR_W'(CONV_TIMEOUT - 1);
         default:             dur_of = '0;
      endcase
   endfunction

   assign last_ch = (ch == CH_W'(CH_NUM - 1));
   assign t_load  = (nxt != state);
   assign t_val   = dur_of(nxt);

   seq_timer u_timer (
      .clk_sys  (CLK_100M),
      .rst_n    (CLK_RST),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   // state register
   always_ff @(posedge CLK_100M or negedge CLK_RST) begin
      if (!CLK_RST)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   // next-state decode; losing ADS_INIT_OK mid-frame overrides everything
   always_comb begin
      nxt      = state;
      ch_inc   = 1'b0;
      pix_take = 1'b0;
      pix_fill = 1'b0;
      abort    = 1'b0;
      if (state != ST_IDLE && !bus.ADS_INIT_OK) begin
         nxt   = ST_IDLE;
         abort = 1'b1;
      end else begin
         case (state)
            ST_IDLE:   if (bus.FRAME_START && bus.ADS_INIT_OK) nxt = ST_IRST;
            ST_IRST:   if (t_zero) nxt = ST_SHR;
            ST_SHR:    if (t_zero) nxt = ST_INTG;
            ST_INTG:   if (t_zero) nxt = ST_SHS;
            ST_SHS:    if (t_zero) nxt = ST_CLK_HI;
            ST_CLK_HI: if (t_zero) nxt = ST_CLK_LO;
            ST_CLK_LO: if (t_zero) nxt = ST_SETTLE;
            ST_SETTLE: if (t_zero) nxt = ST_CONV;
            ST_CONV:   nxt = ST_WAIT;
            ST_WAIT: begin
               // data on the last timeout cycle still counts as data
               if (bus.ADS_AVLAID || t_zero) begin
                  pix_take = 1'b1;
                  pix_fill = !bus.ADS_AVLAID;
                  if (last_ch) begin
                     nxt = ST_DONE;
                  end else begin
                     nxt    = ST_CLK_HI;
                     ch_inc = 1'b1;
                  end
               end
            end
            ST_DONE:   nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
         endcase
      end
   end

   // channel index, cleared whenever idle
   always_ff @(posedge CLK_100M or negedge CLK_RST) begin
      if (!CLK_RST)
         ch <= '0;
      else if (state == ST_IDLE)
         ch <= '0;
      else if (ch_inc)
         ch <= ch + 1'b1;
   end

   // registered Moore strobes decoded from the next state, plus pixel/error pulses
   always_ff @(posedge CLK_100M or negedge CLK_RST) begin
      if (!CLK_RST) begin
         bus.AFE_IRST    <= 1'b0;
         bus.AFE_SHR     <= 1'b0;
         bus.AFE_INTG    <= 1'b0;
         bus.AFE_SHS     <= 1'b0;
         bus.AFE_CLK     <= 1'b0;
         bus.CONV_REQ    <= 1'b0;
         bus.SEQ_BUSY    <= 1'b0;
         bus.FRAME_DONE  <= 1'b0;
         bus.PIX_VALID   <= 1'b0;
         bus.PIX_DATA    <= '0;
         bus.PIX_CH      <= '0;
         bus.ERR_TIMEOUT <= 1'b0;
         bus.ERR_ABORT   <= 1'b0;
      end else begin
         bus.AFE_IRST    <= (nxt == ST_IRST);
         bus.AFE_SHR     <= (nxt == ST_SHR);
         bus.AFE_INTG    <= (nxt == ST_INTG);
         bus.AFE_SHS     <= (nxt == ST_SHS);
         bus.AFE_CLK     <= (nxt == ST_CLK_HI);
         bus.CONV_REQ    <= (nxt == ST_CONV);
         bus.SEQ_BUSY    <= (nxt != ST_IDLE);
         bus.FRAME_DONE  <= (nxt == ST_DONE);
         bus.PIX_VALID   <= pix_take;
         bus.ERR_TIMEOUT <= pix_fill;
         bus.ERR_ABORT   <= abort;
         if (pix_take) begin
            bus.PIX_DATA <= pix_fill ? TIMEOUT_FILL : bus.ADS_ADATA;
            bus.PIX_CH   <= ch;
         end
      end
   end

endmodule

// File: tb/tb_afe_readout_seq.sv
// Directed bench for afe_readout_seq with a fixed-latency ADS model.
module tb_afe_readout_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   afe_readout_seq_if bus();

   afe_readout_seq #(
      .CH_NUM       (4),
      .IRST_CYC     (5),
      .SH_CYC       (3),
      .INTG_CYC     (50),
      .CLK_HALF     (2),
      .SETTLE_CYC   (4),
      .CONV_TIMEOUT (20)
   ) dut (
      .CLK_100M (clk),
      .CLK_RST  (rst_n),
      .bus      (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int start_cyc;

   // ADS model state: per-channel answer latency, 0 means silent
   int          ads_delay [4];
   int          conv_idx;
   int          ads_cnt;
   logic [15:0] ads_data;

   // monitor counters
   int irst_n, shr_n, intg_n, shs_n, clk_hi_n, clk_pulses, clk_run, clk_run_bad;
   int pix_n, fd_n, fd_pv_n, busy_n, to_n, ab_n, first_irst;
   logic        prev_clk;
   logic [15:0] pix_data_q [8];
   logic [5:0]  pix_ch_q   [8];
   logic        pix_err_q  [8];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] outs();
      outs = {31'd0, bus.AFE_IRST, bus.AFE_SHR, bus.AFE_INTG, bus.AFE_SHS, bus.AFE_CLK,
              bus.CONV_REQ, bus.PIX_VALID, bus.SEQ_BUSY, bus.FRAME_DONE,
              bus.ERR_TIMEOUT, bus.ERR_ABORT, bus.PIX_CH, bus.PIX_DATA};
   endfunction

   task automatic clr_mon();
      irst_n = 0; shr_n = 0; intg_n = 0; shs_n = 0; clk_hi_n = 0; clk_pulses = 0;
      clk_run = 0; clk_run_bad = 0; pix_n = 0; fd_n = 0; fd_pv_n = 0; busy_n = 0;
      to_n = 0; ab_n = 0; first_irst = -1; prev_clk = 1'b0; conv_idx = 0; ads_cnt = 0;
   endtask

   // pulse FRAME_START, then re-pulse it at offsets x1/x2 while running
   task automatic run_frame(input int x1, input int x2);
      bus.FRAME_START = 1'b1;
      start_cyc = cyc;
      tick();
      bus.FRAME_START = 1'b0;
      for (int i = 1; i < 1000; i++) begin
         bus.FRAME_START = (i == x1 || i == x2);
         tick();
         if (!bus.SEQ_BUSY) break;
      end
      bus.FRAME_START = 1'b0;
      chk("frame_end", {63'd0, bus.SEQ_BUSY}, 64'd0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ADS model: answers ads_delay cycles after CONV_REQ with 16'h1000 + index
   initial forever begin
      @(posedge clk);
      #1;
      bus.ADS_AVLAID = 1'b0;
      if (ads_cnt > 0) begin
         ads_cnt--;
         if (ads_cnt == 0) begin
            bus.ADS_AVLAID = 1'b1;
            bus.ADS_ADATA  = ads_data;
         end
      end
      if (bus.CONV_REQ) begin
         ads_data = 16'h1000 + 16'(conv_idx);
         if (conv_idx < 4) ads_cnt = ads_delay[conv_idx];
         conv_idx++;
      end
   end

   // per-cycle observation of outputs
   initial forever begin
      @(posedge clk);
      #1;
      if (bus.AFE_IRST) begin
         if (irst_n == 0) first_irst = cyc;
         irst_n++;
      end
      if (bus.AFE_SHR)  shr_n++;
      if (bus.AFE_INTG) intg_n++;
      if (bus.AFE_SHS)  shs_n++;
      if (bus.AFE_CLK) begin
         clk_hi_n++;
         if (!prev_clk) clk_pulses++;
         clk_run++;
      end else begin
         if (prev_clk && clk_run != 2) clk_run_bad++;
         clk_run = 0;
      end
      prev_clk = bus.AFE_CLK;
      if (bus.PIX_VALID) begin
         if (pix_n < 8) begin
            pix_data_q[pix_n] = bus.PIX_DATA;
            pix_ch_q[pix_n]   = bus.PIX_CH;
            pix_err_q[pix_n]  = bus.ERR_TIMEOUT;
         end
         pix_n++;
      end
      if (bus.FRAME_DONE) fd_n++;
      if (bus.FRAME_DONE && bus.PIX_VALID) fd_pv_n++;
      if (bus.SEQ_BUSY)    busy_n++;
      if (bus.ERR_TIMEOUT) to_n++;
      if (bus.ERR_ABORT)   ab_n++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ADS_INIT_OK = 1'b1;
      bus.FRAME_START = 1'b0;
      bus.ADS_AVLAID  = 1'b0;
      bus.ADS_ADATA   = 16'h0;
      ads_delay = '{3, 3, 3, 3};
      clr_mon();

      // reset state
      repeat (3) tick();
      chk("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // nominal frame, with stray FRAME_START during INTG and during DONE
      clr_mon();
      run_frame(20, 110);
      repeat (8) tick();
      chk("nom_irst_start", 64'(first_irst), 64'(start_cyc + 1));
      chk("nom_irst_len", 64'(irst_n), 64'd5);
      chk("nom_shr_len",  64'(shr_n),  64'd3);
      chk("nom_intg_len", 64'(intg_n), 64'd50);
      chk("nom_shs_len",  64'(shs_n),  64'd3);
      chk("nom_clk_pulses", 64'(clk_pulses), 64'd4);
      chk("nom_clk_hi", 64'(clk_hi_n), 64'd8);
      chk("nom_clk_run_bad", 64'(clk_run_bad), 64'd0);
      chk("nom_pix_n", 64'(pix_n), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("nom_pix_ch%0d", i),   64'(pix_ch_q[i]),   64'(i));
         chk($sformatf("nom_pix_data%0d", i), 64'(pix_data_q[i]), 64'(16'h1000 + i));
         chk($sformatf("nom_pix_err%0d", i),  64'(pix_err_q[i]),  64'd0);
      end
      chk("nom_fd_n", 64'(fd_n), 64'd1);
      chk("nom_fd_with_pv", 64'(fd_pv_n), 64'd1);
      chk("nom_busy_len", 64'(busy_n), 64'd110);
      chk("nom_timeouts", 64'(to_n), 64'd0);
      chk("nom_aborts", 64'(ab_n), 64'd0);

      // ADS silent on channel 2
      clr_mon();
      ads_delay = '{3, 3, 0, 3};
      run_frame(0, 0);
      repeat (4) tick();
      chk("to_pix_n", 64'(pix_n), 64'd4);
      chk("to_pix_ch2", 64'(pix_ch_q[2]), 64'd2);
      chk("to_pix_data2", 64'(pix_data_q[2]), 64'hFFFF);
      chk("to_pix_err2", 64'(pix_err_q[2]), 64'd1);
      chk("to_pix_data3", 64'(pix_data_q[3]), 64'h1003);
      chk("to_pix_err3", 64'(pix_err_q[3]), 64'd0);
      chk("to_timeouts", 64'(to_n), 64'd1);
      chk("to_fd_n", 64'(fd_n), 64'd1);
      chk("to_busy_len", 64'(busy_n), 64'd127);

      // data arrives on the last timeout cycle of channel 2
      clr_mon();
      ads_delay = '{3, 3, 20, 3};
      run_frame(0, 0);
      repeat (4) tick();
      chk("edge_pix_n", 64'(pix_n), 64'd4);
      chk("edge_pix_data2", 64'(pix_data_q[2]), 64'h1002);
      chk("edge_pix_err2", 64'(pix_err_q[2]), 64'd0);
      chk("edge_timeouts", 64'(to_n), 64'd0);
      chk("edge_busy_len", 64'(busy_n), 64'd127);

      // ADS_INIT_OK lost during INTG
      clr_mon();
      ads_delay = '{3, 3, 3, 3};
      bus.FRAME_START = 1'b1;
      tick();
      bus.FRAME_START = 1'b0;
      repeat (29) tick();
      chk("ab_intg_before", {63'd0, bus.AFE_INTG}, 64'd1);
      bus.ADS_INIT_OK = 1'b0;
      tick();
      chk("ab_intg_low", {63'd0, bus.AFE_INTG}, 64'd0);
      chk("ab_idle", {63'd0, bus.SEQ_BUSY}, 64'd0);
      chk("ab_err_abort", {63'd0, bus.ERR_ABORT}, 64'd1);
      tick();
      chk("ab_err_pulse", {63'd0, bus.ERR_ABORT}, 64'd0);
      bus.FRAME_START = 1'b1;
      tick();
      bus.FRAME_START = 1'b0;
      repeat (5) tick();
      chk("ab_busy_len", 64'(busy_n), 64'd30);
      chk("ab_intg_len", 64'(intg_n), 64'd22);
      chk("ab_irst_len", 64'(irst_n), 64'd5);
      chk("ab_aborts", 64'(ab_n), 64'd1);
      chk("ab_fd_n", 64'(fd_n), 64'd0);
      chk("ab_pix_n", 64'(pix_n), 64'd0);
      bus.ADS_INIT_OK = 1'b1;
      repeat (3) tick();

      // reset in the middle of readout, during channel 1 CLK_HI
      clr_mon();
      bus.FRAME_START = 1'b1;
      tick();
      bus.FRAME_START = 1'b0;
      repeat (73) tick();
      chk("rst_clk_before", {63'd0, bus.AFE_CLK}, 64'd1);
      chk("rst_pv_before", {63'd0, bus.PIX_VALID}, 64'd1);
      chk("rst_data_before", 64'(bus.PIX_DATA), 64'h1000);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", outs(), 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      clr_mon();
      run_frame(0, 0);
      repeat (4) tick();
      chk("post_pix_n", 64'(pix_n), 64'd4);
      chk("post_pix_ch0", 64'(pix_ch_q[0]), 64'd0);
      chk("post_pix_data0", 64'(pix_data_q[0]), 64'h1000);
      chk("post_pix_ch3", 64'(pix_ch_q[3]), 64'd3);
      chk("post_pix_data3", 64'(pix_data_q[3]), 64'h1003);
      chk("post_fd_n", 64'(fd_n), 64'd1);
      chk("post_busy_len", 64'(busy_n), 64'd110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/afe_readout_seq.md
# afe_readout_seq

Frame sequencer between the AFE front end and the ADS converter control. On each accepted frame start it drives the AFE integrate/sample timing: reset, sample-reset, integrate, sample-signal. It then clocks the AFE analog output one channel at a time. For each channel it requests one ADS conversion and forwards the returned sample as a tagged pixel word. Runs in the 100 MHz domain, after ADS initialisation has completed.

## Interface
- CH_NUM, 64: channels read out per frame (≥1, ≤64)
- IRST_CYC, 100: AFE_IRST high time, cycles
- SH_CYC, 20: AFE_SHR / AFE_SHS high time, cycles
- INTG_CYC, 10000: AFE_INTG high time, cycles (≤65535)
- CLK_HALF, 10: AFE_CLK high time and low time, cycles
- SETTLE_CYC, 20: analog settle time after AFE_CLK falls, cycles
- CONV_TIMEOUT, 255: maximum wait for ADS data, cycles
- CLK_100M  in  1  sole clock; all logic on rising edge
- CLK_RST  in  1  asynchronous active-low reset
- ADS_INIT_OK  in  1  ADS configured; frame allowed only while high
- FRAME_START  in  1  start request, sampled in IDLE only
- AFE_IRST, AFE_SHR, AFE_INTG, AFE_SHS, AFE_CLK  out  1 each  AFE timing strobes
- CONV_REQ  out  1  one-cycle ADS conversion request
- ADS_AVLAID  in  1  ADS channel-A data valid, one-cycle pulse
- ADS_ADATA  in  16  ADS channel-A sample
- PIX_VALID  out  1  one-cycle pixel strobe
- PIX_DATA  out  16  pixel sample
- PIX_CH  out  6  channel index of PIX_DATA
- SEQ_BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse at frame end
- ERR_TIMEOUT  out  1  one-cycle pulse on a conversion timeout
- ERR_ABORT  out  1  one-cycle pulse on an ADS_INIT_OK loss mid-frame

## Operation
- States: IDLE → IRST → SHR → INTG → SHS → CLK_HI → CLK_LO → SETTLE → CONV → WAIT → (CLK_HI | DONE) → IDLE.
- A single 16-bit down-timer is loaded with N−1 on state entry. A timed state exits when the timer is 0, so each timed state lasts exactly N cycles.
- Timed states and their N values:
  - IRST: IRST_CYC
  - SHR and SHS: SH_CYC
  - INTG: INTG_CYC
  - CLK_HI and CLK_LO: CLK_HALF
  - SETTLE: SETTLE_CYC
- State-decoded outputs, all registered (Moore):
  - AFE_IRST=IRST, AFE_SHR=SHR, AFE_INTG=INTG, AFE_SHS=SHS, AFE_CLK=CLK_HI.
  - CONV_REQ=CONV, which lasts 1 cycle.
- IDLE → IRST when FRAME_START=1 and ADS_INIT_OK=1. FRAME_START in any other state is ignored, with no queueing.
- Channel counter ch is cleared in IDLE.
- WAIT behaviour:
  - ADS_AVLAID=1: capture ADS_ADATA. Next cycle, PIX_VALID=1, PIX_DATA=captured value, PIX_CH=ch.
  - CONV_TIMEOUT cycles elapse without ADS_AVLAID: PIX_VALID=1 with PIX_DATA=16'hFFFF, and ERR_TIMEOUT=1 in the same cycle.
  - ADS_AVLAID on the final timeout cycle: the data wins and no error is raised.
  - ADS_AVLAID outside WAIT is ignored.
- Leaving WAIT:
  - If ch==CH_NUM−1 → DONE.
  - Otherwise ch+1 → CLK_HI.
- DONE lasts 1 cycle with FRAME_DONE=1, then → IDLE.
- ADS_INIT_OK=0 in any non-IDLE state:
  - Next cycle: IDLE, all strobes low, ERR_ABORT=1, no FRAME_DONE, no PIX_VALID for the abandoned channel.
- Reset values: every output is 0, PIX_DATA=0, PIX_CH=0, state=IDLE, ch=0, timer=0. Reset asserted mid-frame returns to IDLE immediately.

## Timing
- FRAME_START sampled at cycle k → AFE_IRST high for cycles k+1 … k+IRST_CYC.
- Strobe phases are contiguous, with no gap cycles between IRST, SHR, INTG and SHS, or between CLK_HI and CLK_LO.
- Per-channel time is 2·CLK_HALF + SETTLE_CYC + 1 + w:
  - w is the WAIT occupancy, 1 … CONV_TIMEOUT.
  - WAIT is exited the cycle after the one in which ADS_AVLAID is sampled.
- PIX_VALID is asserted 1 cycle after ADS_AVLAID, in the same cycle as the first CLK_HI of the next channel or as DONE.
- The last PIX_VALID and FRAME_DONE are asserted in the same cycle.
- Frame length = IRST_CYC + 2·SH_CYC + INTG_CYC + Σ per-channel time + 1 (DONE).

## Structure
- Shared include/package afe_seq_pkg:
  - state encoding constants
  - timer width (16)
  - channel width (6)
  - timeout fill value 16'hFFFF
- One sub-module, seq_timer: loadable 16-bit down-counter with load, load value, and zero flag.
- FSM, channel counter and output registers live in the top module.

## Test plan
Bench parameters: CH_NUM=4, IRST_CYC=5, SH_CYC=3, INTG_CYC=50, CLK_HALF=2, SETTLE_CYC=4, CONV_TIMEOUT=20. The ADS model answers 3 cycles after CONV_REQ.
- Nominal frame, data 16'h1000+ch:
  - AFE_IRST high 5 cycles, SHR 3, INTG 50, SHS 3.
  - 4 AFE_CLK pulses, each 2 high / 2 low.
  - PIX_VALID ×4 with PIX_CH 0..3 and PIX_DATA 16'h1000..16'h1003.
  - FRAME_DONE once, coincident with the 4th PIX_VALID.
- ADS model silent on ch 2:
  - After 20 WAIT cycles, PIX_DATA=16'hFFFF with PIX_CH=2 and ERR_TIMEOUT pulse.
  - Frame completes normally.
- ADS_AVLAID exactly on the 20th WAIT cycle: real data is delivered and ERR_TIMEOUT stays 0.
- ADS_INIT_OK dropped during INTG:
  - Next cycle IDLE, AFE_INTG=0, ERR_ABORT pulse.
  - No FRAME_DONE, no PIX_VALID.
  - FRAME_START with ADS_INIT_OK=0 is ignored.
- FRAME_START pulses during a frame are ignored. CLK_RST asserted mid-readout forces all outputs to 0 asynchronously, and the next frame after release starts at ch 0.
